imem_loader: RTL

- Boot-time writer for the instruction memory.
- Accepts a byte stream (from UART/debug link) carrying a word count and little-endian 32-bit instruction words.
- Assembles the bytes into words and issues single-cycle writes to the IMEM write port at consecutive word-aligned byte addresses from 0.
- Holds the core in reset (busy_o) until the program is fully loaded.

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader that turns a byte stream (16-bit little-endian word count, then
// little-endian 32-bit words) into sequential IMEM writes, holding the core in reset.
`timescale 1ns/1ps

module imem_loader #(
   parameter int DEPTH  = 1001,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [15:0]       words_loaded_o
);

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WLAST,
      DONE,
      ERR
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      state;
   state_t      state_nx;
   logic [15:0] count;
   logic [15:0] index;
   logic [1:0]  lane;
   logic [23:0] partial;
   logic        accept;
   logic [15:0] hdr_count;
   logic        hdr_zero;
   logic        hdr_too_big;
   logic        last_word;
   logic        word_done;

   assign rx_ready_o  = (state == HDR0) || (state == HDR1) || (state == DATA);
   assign busy_o      = rx_ready_o || (state == WLAST);
   assign accept      = rx_valid_i && rx_ready_o;

   // The high count byte is combined with the stored low byte so HDR1 can decide in one cycle.
   assign hdr_count   = {rx_data_i, count[7:0]};
   assign hdr_zero    = (hdr_count == 16'd0);
   assign hdr_too_big = ({1'b0, hdr_count} > DEPTH_L);
   assign last_word   = ((index + 16'd1) == count);
   assign word_done   = accept && (state == DATA) && (lane == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE, ERR: begin
            if (start_i) begin
               state_nx = HDR0;
            end
         end
         HDR0: begin
            if (accept) begin
               state_nx = HDR1;
            end
         end
         HDR1: begin
            if (accept) begin
               if (hdr_zero) begin
                  state_nx = DONE;
               end else if (hdr_too_big) begin
                  state_nx = ERR;
               end else begin
                  state_nx = DATA;
               end
            end
         end
         DATA: begin
            if (word_done && last_word) begin
               state_nx = WLAST;
            end
         end
         WLAST: begin
            state_nx = DONE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Write port is registered: the write lands the cycle after the lane-3 byte,
   // while the next lane-0 byte can already be accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count          <= '0;
         index          <= '0;
         lane           <= '0;
         partial        <= '0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         done_o         <= 1'b0;
         error_o        <= 1'b0;
         words_loaded_o <= '0;
      end else begin
         mem_we_o <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  count          <= '0;
                  index          <= '0;
                  lane           <= '0;
                  done_o         <= 1'b0;
                  error_o        <= 1'b0;
                  words_loaded_o <= '0;
               end
            end
            HDR0: begin
               if (accept) begin
                  count[7:0] <= rx_data_i;
               end
            end
            HDR1: begin
               if (accept) begin
                  count[15:8] <= rx_data_i;
                  if (hdr_zero) begin
                     done_o <= 1'b1;
                  end else if (hdr_too_big) begin
                     error_o <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0: partial[7:0]   <= rx_data_i;
                     2'd1: partial[15:8]  <= rx_data_i;
                     2'd2: partial[23:16] <= rx_data_i;
                     default: begin
                        mem_we_o       <= 1'b1;
                        mem_addr_o     <= ADDR_W'({index, 2'b00});
                        mem_wdata_o    <= {rx_data_i, partial};
                        index          <= index + 16'd1;
                        words_loaded_o <= index + 16'd1;
                     end
                  endcase
               end
            end
            WLAST: begin
               done_o <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
